// File: rtl/uart_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_tx
//  Description : Watches the operate, target and game-state command bytes,
//                queues any channel whose byte changed, and sends one queued
//                byte per frame as UART 8N1 (LSB first) on tx.
//                Fixed priority: target > operate > game.
//  Optional    : define UART_PARITY_EN to add an even-parity bit between
//                the last data bit and the stop bit (8E1, 11 bit-times).
//  Ports       : clk                    system clock
//                res                    asynchronous active-low reset
//                data_target_script     target-machine command byte
//                data_operate_script    operate command byte
//                data_game_state_script game-state command byte
//                force_resend           pulse: mark all channels pending
//                tx                     UART serial line, idle high
//                busy                   frame in flight (START..STOP)
//                tx_done                pulse on the last cycle of STOP
//                granted_ch             0 target, 1 operate, 2 game
//                frame_cnt              completed frames, wraps at 256
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_tx #(
    parameter int BAUD_DIV = 868,
    parameter int CNT_W    = 10
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] data_target_script,
    input  logic [7:0] data_operate_script,
    input  logic [7:0] data_game_state_script,
    input  logic       force_resend,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic [1:0] granted_ch,
    output logic [7:0] frame_cnt
);

    localparam logic [CNT_W-1:0] c_baud_last = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] c_baud_pre  = CNT_W'(BAUD_DIV - 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_shadow_tgt;
    logic [7:0]       r_shadow_op;
    logic [7:0]       r_shadow_game;
    logic [2:0]       r_pending;     // [0] target, [1] operate, [2] game
`ifdef UART_PARITY_EN
    logic             r_parity;
`endif

    logic [2:0]       w_changed;
    logic             w_grant;
    logic [1:0]       w_grant_ch;
    logic [7:0]       w_grant_data;

    always_comb begin
        w_changed[0] = (data_target_script     != r_shadow_tgt);
        w_changed[1] = (data_operate_script    != r_shadow_op);
        w_changed[2] = (data_game_state_script != r_shadow_game);
        w_grant      = (r_state == ST_IDLE) && (|r_pending);
        // Priority encoder; the fall-through choice is irrelevant when
        // nothing is pending because w_grant is then low.
        w_grant_ch   = 2'd2;
        w_grant_data = r_shadow_game;
        if (r_pending[0]) begin
            w_grant_ch   = 2'd0;
            w_grant_data = r_shadow_tgt;
        end else if (r_pending[1]) begin
            w_grant_ch   = 2'd1;
            w_grant_data = r_shadow_op;
        end
    end

    // Change capture. Shadows simply follow the inputs (a write of an equal
    // value is a no-op). A new change or a resend request outranks the
    // clear-on-grant, so a byte that changes on its grant cycle stays
    // queued while the frame carries the previous shadow value.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_shadow_tgt  <= 8'h00;
            r_shadow_op   <= 8'h00;
            r_shadow_game <= 8'h00;
            r_pending     <= 3'b000;
        end else begin
            r_shadow_tgt  <= data_target_script;
            r_shadow_op   <= data_operate_script;
            r_shadow_game <= data_game_state_script;
            for (int i = 0; i < 3; i++) begin
                if (w_changed[i] || force_resend) begin
                    r_pending[i] <= 1'b1;
                end else if (w_grant && (w_grant_ch == 2'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Frame sequencer. tx is registered, so the value assigned on the edge
    // that enters a state is the line level for that whole bit time.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            granted_ch <= 2'd0;
            frame_cnt  <= 8'h00;
`ifdef UART_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    tx        <= 1'b1;
                    busy      <= 1'b0;
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                    if (w_grant) begin
                        r_shift    <= w_grant_data;
                        granted_ch <= w_grant_ch;
`ifdef UART_PARITY_EN
                        r_parity   <= ^w_grant_data;
`endif
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_baud_last) begin
                        r_cnt   <= '0;
                        tx      <= r_shift[0];
                        r_state <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_baud_last) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx      <= r_parity;
                            r_state <= ST_PARITY;
`else
                            tx      <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            tx        <= r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (r_cnt == c_baud_last) begin
                        r_cnt   <= '0;
                        tx      <= 1'b1;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (r_cnt == c_baud_last) begin
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        // Registered one cycle early so the pulse and the
                        // new count coincide with the final STOP cycle.
                        if (r_cnt == c_baud_pre) begin
                            tx_done   <= 1'b1;
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_tx
//  Description : Directed self-checking bench for uart_cmd_tx at BAUD_DIV=4.
//                Honours UART_PARITY_EN (11 bit-times per frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_tx;

    localparam int BD = 4;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic [7:0] d_tgt = 8'h00;
    logic [7:0] d_op = 8'h00;
    logic [7:0] d_game = 8'h00;
    logic       force_resend = 1'b0;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic [1:0] granted_ch;
    logic [7:0] frame_cnt;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_frames = 8'h00;

    always #5 clk = ~clk;

    uart_cmd_tx #(.BAUD_DIV(BD), .CNT_W(3)) dut (
        .clk                    (clk),
        .res                    (res),
        .data_target_script     (d_tgt),
        .data_operate_script    (d_op),
        .data_game_state_script (d_game),
        .force_resend           (force_resend),
        .tx                     (tx),
        .busy                   (busy),
        .tx_done                (tx_done),
        .granted_ch             (granted_ch),
        .frame_cnt              (frame_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits for busy; returns the number of edges it took.
    task automatic wait_start(input string name, input int limit, output int waited);
        waited = 0;
        while (busy !== 1'b1 && waited < limit) begin
            tick();
            waited++;
        end
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s: no frame start within %0d cycles (busy=%b)", name, limit, busy);
        else n_pass++;
    endtask

    // Called at the first cycle of busy (one ns after the grant edge).
    // Samples every bit at the second cycle of its bit time.
    task automatic recv_frame(input string name, input logic [7:0] data, input logic [1:0] ch);
        logic [NB-1:0] got;
        logic [NB-1:0] expv;
`ifdef UART_PARITY_EN
        expv = {1'b1, ^data, data, 1'b0};
`else
        expv = {1'b1, data, 1'b0};
`endif
        n_total++;
        if (granted_ch !== ch) $display("FAIL %s granted_ch: got %0d want %0d", name, granted_ch, ch);
        else n_pass++;
        got = '0;
        tick();
        got[0] = tx;
        for (int b = 1; b < NB; b++) begin
            repeat (BD) tick();
            got[b] = tx;
        end
        n_total++;
        if (got !== expv) $display("FAIL %s bits: got %b want %b", name, got, expv);
        else n_pass++;
        tick();
        n_total++;
        if (tx_done !== 1'b0) $display("FAIL %s early tx_done: got %b want 0", name, tx_done);
        else n_pass++;
        tick();
        exp_frames = exp_frames + 8'd1;
        n_total++;
        if (tx_done !== 1'b1) $display("FAIL %s tx_done at cycle %0d: got %b want 1", name, NB*BD, tx_done);
        else n_pass++;
        n_total++;
        if (frame_cnt !== exp_frames) $display("FAIL %s frame_cnt: got %0d want %0d", name, frame_cnt, exp_frames);
        else n_pass++;
        tick();
        n_total++;
        if (tx_done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1)
            $display("FAIL %s end of frame: tx_done=%b busy=%b tx=%b want 0 0 1", name, tx_done, busy, tx);
        else n_pass++;
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (busy !== 1'b0 || tx !== 1'b1 || tx_done !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL %s: %0d cycles with activity, want 0", name, bad);
        else n_pass++;
    endtask

    task automatic test_reset;
        repeat (3) tick();
        n_total++;
        if ({tx, busy, tx_done, granted_ch, frame_cnt} !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00})
            $display("FAIL reset outputs: tx=%b busy=%b done=%b ch=%0d cnt=%0d want 1 0 0 0 0",
                     tx, busy, tx_done, granted_ch, frame_cnt);
        else n_pass++;
        res = 1'b1;
        check_quiet("idle after reset", 100);
        n_total++;
        if (frame_cnt !== 8'h00) $display("FAIL idle frame_cnt: got %0d want 0", frame_cnt);
        else n_pass++;
    endtask

    task automatic test_single_byte;
        int w;
        d_tgt = 8'h15;
        wait_start("single start", 10, w);
        n_total++;
        if (w != 2) $display("FAIL single latency: got %0d edges want 2", w);
        else n_pass++;
        recv_frame("single 15", 8'h15, 2'd0);
    endtask

    task automatic test_priority;
        int w;
        d_tgt  = 8'h05;
        d_op   = 8'h0A;
        d_game = 8'h12;
        wait_start("prio start", 10, w);
        recv_frame("prio tgt", 8'h05, 2'd0);
        wait_start("prio op start", 10, w);
        n_total++;
        if (w != 1) $display("FAIL prio gap op: got %0d idle cycles want 1", w);
        else n_pass++;
        recv_frame("prio op", 8'h0A, 2'd1);
        wait_start("prio game start", 10, w);
        n_total++;
        if (w != 1) $display("FAIL prio gap game: got %0d idle cycles want 1", w);
        else n_pass++;
        recv_frame("prio game", 8'h12, 2'd2);
        check_quiet("prio drained", 20);
    endtask

    task automatic test_overwrite;
        int w;
        d_tgt = 8'h33;
        wait_start("ovw start", 10, w);
        d_op = 8'h02;
        fork
            recv_frame("ovw tgt", 8'h33, 2'd0);
            begin
                repeat (8) @(posedge clk);
                #2 d_op = 8'h06;
            end
        join
        wait_start("ovw op start", 10, w);
        recv_frame("ovw op", 8'h06, 2'd1);
        check_quiet("ovw no extra frame", 50);
    endtask

    task automatic test_reset_mid_frame;
        int w;
        d_tgt = 8'h5A;
        wait_start("rst start", 10, w);
        repeat (17) tick();      // inside data bit 3
        res    = 1'b0;
        d_tgt  = 8'h00;
        d_op   = 8'h00;
        d_game = 8'h00;
        #1;
        n_total++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || frame_cnt !== 8'h00)
            $display("FAIL reset mid-frame: tx=%b busy=%b done=%b cnt=%0d want 1 0 0 0",
                     tx, busy, tx_done, frame_cnt);
        else n_pass++;
        exp_frames = 8'h00;
        repeat (3) tick();
        res = 1'b1;
        check_quiet("after mid-frame reset", 60);
    endtask

    task automatic test_wrap_resend;
        int  bad;
        int  n;
        logic [7:0] cnt_at_256;
        bad = 0;
        cnt_at_256 = 8'hFF;
        for (int i = 0; i < 258; i++) begin
            if (i % 3 == 0) begin
                force_resend = 1'b1;
                tick();
                force_resend = 1'b0;
            end else begin
                tick();
            end
            n = 0;
            while (tx_done !== 1'b1 && n < 200) begin
                tick();
                n++;
            end
            if (tx_done !== 1'b1) begin
                bad++;
                break;
            end
            exp_frames = exp_frames + 8'd1;
            if (granted_ch !== 2'(i % 3) || frame_cnt !== exp_frames) bad++;
            if (i == 255) cnt_at_256 = frame_cnt;
        end
        n_total++;
        if (bad != 0) $display("FAIL resend sequence: %0d bad frames want 0", bad);
        else n_pass++;
        n_total++;
        if (cnt_at_256 !== 8'h00) $display("FAIL frame_cnt wrap: got %0d want 0", cnt_at_256);
        else n_pass++;
        repeat (2) tick();
        check_quiet("resend drained", 20);
    endtask

    task automatic test_odd_byte;
        int w;
        d_game = 8'h07;
        wait_start("odd start", 10, w);
        recv_frame("odd 07", 8'h07, 2'd2);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_priority();
        test_overwrite();
        test_reset_mid_frame();
        test_wrap_resend();
        test_odd_byte();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
